// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the receive deframer and its FIFO.
package uart_rx_pkg;

  localparam logic [1:0] DLEN_5 = 2'b00;
  localparam logic [1:0] DLEN_6 = 2'b01;
  localparam logic [1:0] DLEN_7 = 2'b10;
  localparam logic [1:0] DLEN_8 = 2'b11;

  localparam int ST_PAR   = 0;
  localparam int ST_FRM   = 1;
  localparam int ST_START = 2;
  localparam int ST_BRK   = 3;
  localparam int ST_W     = 4;

  // start + data + parity + two stop bits
  function automatic int frame_w(input int max_data_w);
    return max_data_w + 4;
  endfunction

  function automatic int data_len(input logic [1:0] code);
    return 5 + int'(code);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push may coincide with pop when full.
module sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/rx_deframe_fifo.sv
// Receive deframer: decodes a parallel frame under runtime config and queues
// data plus status in a small FIFO toward the read path.
module rx_deframe_fifo
  import uart_rx_pkg::*;
#(
  parameter  int MAX_DATA_W = 8,
  parameter  int FIFO_DEPTH = 4,
  localparam int FRAME_W    = frame_w(MAX_DATA_W)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [FRAME_W-1:0]            frame_in,
  input  logic                          frame_valid,
  input  logic [1:0]                    cfg_data_len,
  input  logic                          cfg_parity_en,
  input  logic                          cfg_parity_odd,
  input  logic                          cfg_stop2,
  output logic [MAX_DATA_W-1:0]         data_out,
  output logic [3:0]                    status_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  input  logic                          clear_overrun
);

  localparam int ENTRY_W = MAX_DATA_W + ST_W;

  function automatic logic pick(input logic [FRAME_W-1:0] f, input int pos);
    logic b;
    b = 1'b0;
    for (int i = 0; i < FRAME_W; i++) begin
      if (i == pos) b = f[i];
    end
    return b;
  endfunction

  int                    w_len;
  int                    w_stop_pos;
  logic [MAX_DATA_W-1:0] w_data;
  logic                  w_par_bit;
  logic                  w_stop1;
  logic                  w_stop2;
  logic [ST_W-1:0]       w_status;

  logic [ENTRY_W-1:0]    w_rdata;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  r_overrun;

  always_comb begin
    w_len = data_len(cfg_data_len);
    if (w_len > MAX_DATA_W) w_len = MAX_DATA_W;

    w_data = '0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < w_len) w_data[i] = frame_in[i+1];
    end

    w_par_bit  = cfg_parity_en ? pick(frame_in, 1 + w_len) : 1'b0;
    w_stop_pos = cfg_parity_en ? 2 + w_len : 1 + w_len;
    w_stop1    = pick(frame_in, w_stop_pos);
    w_stop2    = cfg_stop2 ? pick(frame_in, w_stop_pos + 1) : 1'b1;

    w_status           = '0;
    w_status[ST_START] = frame_in[0];
    w_status[ST_FRM]   = !w_stop1 || !w_stop2;
    // Odd mode wants data^parity == 1, so an error is the XOR matching the odd flag inverted.
    w_status[ST_PAR]   = cfg_parity_en && ((^w_data ^ w_par_bit) == cfg_parity_odd ? 1'b0 : 1'b1);
    w_status[ST_BRK]   = !frame_in[0] && (w_data == '0) && !w_par_bit && !w_stop1;
  end

  assign w_pop  = !w_empty && out_ready;
  assign w_push = frame_valid && (!w_full || w_pop);
  assign w_drop = frame_valid && w_full && !w_pop;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_push  (w_push),
    .i_wdata ({w_status, w_data}),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  // A new drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          r_overrun <= 1'b0;
    else if (w_drop)       r_overrun <= 1'b1;
    else if (clear_overrun) r_overrun <= 1'b0;
  end

  assign out_valid  = !w_empty;
  assign data_out   = w_empty ? '0 : w_rdata[MAX_DATA_W-1:0];
  assign status_out = w_empty ? '0 : w_rdata[ENTRY_W-1:MAX_DATA_W];
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_rx_deframe_fifo.sv
// Directed bench for rx_deframe_fifo with hand-computed expectations.
module tb_rx_deframe_fifo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] frame_in;
  logic        frame_valid;
  logic [1:0]  cfg_data_len;
  logic        cfg_parity_en;
  logic        cfg_parity_odd;
  logic        cfg_stop2;
  logic [7:0]  data_out;
  logic [3:0]  status_out;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fifo_count;
  logic        overrun;
  logic        clear_overrun;

  int total = 0;
  int bad   = 0;

  rx_deframe_fifo #(.MAX_DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .frame_in       (frame_in),
    .frame_valid    (frame_valid),
    .cfg_data_len   (cfg_data_len),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_stop2      (cfg_stop2),
    .data_out       (data_out),
    .status_out     (status_out),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .fifo_count     (fifo_count),
    .overrun        (overrun),
    .clear_overrun  (clear_overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [11:0] f);
    frame_in    = f;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
  endtask

  function automatic logic [11:0] f8n1(input logic [7:0] d);
    return (12'h200 | {3'b000, d, 1'b0});
  endfunction

  logic [7:0] exp_drain [4];

  initial begin
    reset_n = 1'b0; frame_in = '0; frame_valid = 1'b0;
    cfg_data_len = 2'b11; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
    out_ready = 1'b0; clear_overrun = 1'b0;
    exp_drain[0] = 8'h11; exp_drain[1] = 8'h22; exp_drain[2] = 8'h33; exp_drain[3] = 8'h44;

    tick(); tick();
    chk("rst_valid",   32'(out_valid),  32'd0);
    chk("rst_count",   32'(fifo_count), 32'd0);
    chk("rst_overrun", 32'(overrun),    32'd0);
    chk("rst_data",    32'(data_out),   32'd0);
    chk("rst_status",  32'(status_out), 32'd0);
    reset_n = 1'b1;
    tick();

    // 8E1 good frame, then popped on the following edge
    out_ready = 1'b1;
    send(12'hD4A);
    chk("e1_valid",  32'(out_valid),  32'd1);
    chk("e1_data",   32'(data_out),   32'hA5);
    chk("e1_status", 32'(status_out), 32'b0000);
    tick();
    chk("e1_popped", 32'(out_valid),  32'd0);

    send(12'hF4A);
    chk("e1_par_data",   32'(data_out),   32'hA5);
    chk("e1_par_status", 32'(status_out), 32'b0001);
    tick();

    // 7O2
    cfg_data_len = 2'b10; cfg_parity_odd = 1'b1; cfg_stop2 = 1'b1;
    send(12'h782);
    chk("o2_data",   32'(data_out),   32'h41);
    chk("o2_status", 32'(status_out), 32'b0000);
    tick();
    send(12'h382);
    chk("o2_stop_data",   32'(data_out),   32'h41);
    chk("o2_stop_status", 32'(status_out), 32'b0010);
    tick();

    // 8N1 break and start error
    cfg_data_len = 2'b11; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
    send(12'h000);
    chk("brk_data",   32'(data_out),   32'h00);
    chk("brk_status", 32'(status_out), 32'b1010);
    tick();
    send(12'h201);
    chk("start_data",   32'(data_out),   32'h00);
    chk("start_status", 32'(status_out), 32'b0100);
    tick();
    chk("start_popped", 32'(out_valid), 32'd0);

    // Overflow: five frames into a four-deep FIFO
    out_ready = 1'b0;
    send(f8n1(8'h11)); send(f8n1(8'h22)); send(f8n1(8'h33)); send(f8n1(8'h44));
    chk("ovf_full_count", 32'(fifo_count), 32'd4);
    chk("ovf_no_overrun", 32'(overrun),    32'd0);
    send(f8n1(8'h55));
    chk("ovf_count",   32'(fifo_count), 32'd4);
    chk("ovf_overrun", 32'(overrun),    32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d", i), 32'(data_out), 32'(exp_drain[i]));
      tick();
    end
    out_ready = 1'b0;
    chk("drain_empty",   32'(out_valid), 32'd0);
    chk("drain_sticky",  32'(overrun),   32'd1);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    chk("ovf_cleared", 32'(overrun), 32'd0);

    // Full FIFO with simultaneous push and pop
    send(f8n1(8'h66)); send(f8n1(8'h77)); send(f8n1(8'h88)); send(f8n1(8'h99));
    chk("pp_pre_count", 32'(fifo_count), 32'd4);
    out_ready = 1'b1;
    send(f8n1(8'hAA));
    out_ready = 1'b0;
    chk("pp_count",   32'(fifo_count), 32'd4);
    chk("pp_overrun", 32'(overrun),    32'd0);
    chk("pp_head",    32'(data_out),   32'h77);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pp_drain_count", 32'(fifo_count), 32'd3);
    chk("pp_drain_head",  32'(data_out),   32'h88);

    // Asynchronous reset mid-drain, with a frame strobe ignored during reset
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid),  32'd0);
    chk("arst_count", 32'(fifo_count), 32'd0);
    chk("arst_data",  32'(data_out),   32'd0);
    send(f8n1(8'h5A));
    chk("arst_ignore", 32'(fifo_count), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
